// File: rtl/hififo_read_request.sv
//------------------------------------------------------------------------------
// Module   : hififo_read_request
// Purpose  : Turns descriptor units into tagged PCIe memory read requests,
//            with a tag pool and receive-FIFO credit accounting.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module hififo_read_request #(
  parameter int BS      = 7,
  parameter int AMSB    = 63,
  parameter int TBITS   = 5,
  parameter int CMSB    = 9,
  parameter int CREDITS = 512
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             abort,
  input  logic [AMSB:0]    req_addr,
  input  logic             req_valid,
  output logic             req_ack,
  output logic             rr_valid,
  output logic [AMSB:0]    rr_addr,
  output logic [TBITS-1:0] rr_tag,
  input  logic             rr_ready,
  input  logic             rc_valid,
  input  logic             rc_last,
  input  logic [TBITS-1:0] rc_tag,
  input  logic             credit_return,
  output logic [TBITS:0]   outstanding,
  output logic             idle,
  output logic             error
);

  localparam int              NTAGS      = 1 << TBITS;
  localparam logic [CMSB:0]   CREDIT_MAX = (CMSB + 1)'(CREDITS);

  logic [NTAGS-1:0] busy;
  logic [NTAGS-1:0] busy_next;
  logic [TBITS:0]   count_next;
  logic [CMSB:0]    credit;
  logic [TBITS-1:0] free_tag;
  logic             tag_avail;
  logic             free_hit;
  logic             free_bad;
  logic             credit_overflow;
  logic             unused_addr_lsbs;

  assign unused_addr_lsbs = ^req_addr[BS-1:0];

  assign tag_avail = ~&busy;

  // Lowest-index free tag, taken from the mask before this cycle's frees.
  always_comb begin
    free_tag = '0;
    for (int i = NTAGS - 1; i >= 0; i--) begin
      if (!busy[i]) free_tag = TBITS'(i);
    end
  end

  assign req_ack = reset_n & req_valid & ~abort & tag_avail & (credit != '0)
                 & (~rr_valid | rr_ready);

  assign free_hit        = rc_valid & rc_last;
  assign free_bad        = free_hit & ~busy[rc_tag];
  assign credit_overflow = credit_return & ~req_ack & (credit == CREDIT_MAX);

  always_comb begin
    busy_next = busy;
    if (free_hit) busy_next[rc_tag] = 1'b0;
    if (req_ack)  busy_next[free_tag] = 1'b1;
    count_next = '0;
    for (int i = 0; i < NTAGS; i++) begin
      count_next = count_next + (TBITS + 1)'(busy_next[i]);
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rr_valid <= 1'b0;
      rr_addr  <= '0;
      rr_tag   <= '0;
    end else if (req_ack) begin
      rr_valid <= 1'b1;
      rr_addr  <= {req_addr[AMSB:BS], {BS{1'b0}}};
      rr_tag   <= free_tag;
    end else if (rr_ready) begin
      rr_valid <= 1'b0;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      busy        <= '0;
      outstanding <= '0;
    end else begin
      busy        <= busy_next;
      outstanding <= count_next;
    end
  end

  // Simultaneous ack and return cancel; a return at full capacity is dropped.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      credit <= CREDIT_MAX;
    end else begin
      case ({req_ack, credit_return})
        2'b10:   credit <= credit - 1'b1;
        2'b01:   if (credit != CREDIT_MAX) credit <= credit + 1'b1;
        default: credit <= credit;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) error <= 1'b0;
    else          error <= error | free_bad | credit_overflow;
  end

  assign idle = (outstanding == '0) & ~rr_valid;

endmodule

`default_nettype wire

// File: tb/tb_hififo_read_request.sv
//------------------------------------------------------------------------------
// Module   : tb_hififo_read_request
// Purpose  : Directed self-checking bench for hififo_read_request.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_hififo_read_request;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        abort, req_valid, rr_ready, rc_valid, rc_last, credit_return;
  logic [63:0] req_addr;
  logic [4:0]  rc_tag;
  logic        req_ack, rr_valid, idle, error;
  logic [63:0] rr_addr;
  logic [4:0]  rr_tag;
  logic [5:0]  outstanding;

  // Second instance with a 4-unit receive FIFO.
  logic        req_valid2, rr_ready2, credit_return2;
  logic        req_ack2, rr_valid2, idle2, error2;
  logic [63:0] rr_addr2;
  logic [4:0]  rr_tag2;
  logic [5:0]  outstanding2;

  int checks   = 0;
  int failures = 0;

  always #5 clock = ~clock;

  hififo_read_request dut (
    .clock(clock), .reset_n(reset_n), .abort(abort), .req_addr(req_addr),
    .req_valid(req_valid), .req_ack(req_ack), .rr_valid(rr_valid),
    .rr_addr(rr_addr), .rr_tag(rr_tag), .rr_ready(rr_ready),
    .rc_valid(rc_valid), .rc_last(rc_last), .rc_tag(rc_tag),
    .credit_return(credit_return), .outstanding(outstanding), .idle(idle),
    .error(error)
  );

  hififo_read_request #(.CREDITS(4)) dut2 (
    .clock(clock), .reset_n(reset_n), .abort(1'b0), .req_addr(64'h8000),
    .req_valid(req_valid2), .req_ack(req_ack2), .rr_valid(rr_valid2),
    .rr_addr(rr_addr2), .rr_tag(rr_tag2), .rr_ready(rr_ready2),
    .rc_valid(1'b0), .rc_last(1'b0), .rc_tag(5'd0),
    .credit_return(credit_return2), .outstanding(outstanding2), .idle(idle2),
    .error(error2)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  initial begin
    reset_n = 1'b0; abort = 1'b0; req_valid = 1'b1; rr_ready = 1'b0;
    rc_valid = 1'b0; rc_last = 1'b0; rc_tag = '0; credit_return = 1'b0;
    req_addr = 64'h0; req_valid2 = 1'b0; rr_ready2 = 1'b1; credit_return2 = 1'b0;
    #2;
    chk("rst_ack", req_ack, 0);
    chk("rst_rr_valid", rr_valid, 0);
    chk("rst_idle", idle, 1);
    chk("rst_outstanding", outstanding, 0);
    chk("rst_error", error, 0);
    req_valid = 1'b0;
    step(); step();
    reset_n = 1'b1;
    step();

    // Basic issue: three back-to-back units, low address bits masked
    req_valid = 1'b1; req_addr = 64'h1000; rr_ready = 1'b1;
    #1 chk("t1_ack", req_ack, 1);
    step();
    chk("t1_v0", rr_valid, 1); chk("t1_a0", rr_addr, 64'h1000); chk("t1_g0", rr_tag, 0);
    req_addr = 64'h1080;
    step();
    chk("t1_a1", rr_addr, 64'h1080); chk("t1_g1", rr_tag, 1);
    req_addr = 64'h1137;
    step();
    chk("t1_a2", rr_addr, 64'h1100); chk("t1_g2", rr_tag, 2);
    req_valid = 1'b0;
    step();
    chk("t1_drop", rr_valid, 0); chk("t1_out", outstanding, 3); chk("t1_idle", idle, 0);

    // Backpressure holds the request stable
    req_valid = 1'b1; req_addr = 64'h2000; rr_ready = 1'b0;
    step();
    chk("t2_v", rr_valid, 1); chk("t2_g", rr_tag, 3);
    req_addr = 64'h3000;
    for (int i = 0; i < 5; i++) begin
      #1 chk("t2_ack_blk", req_ack, 0);
      chk("t2_addr_hold", rr_addr, 64'h2000);
      chk("t2_tag_hold", rr_tag, 3);
      step();
    end
    chk("t2_out", outstanding, 4);
    rr_ready = 1'b1;
    #1 chk("t2_ack_rel", req_ack, 1);
    step();
    chk("t2_a2", rr_addr, 64'h3000); chk("t2_g2", rr_tag, 4);
    req_valid = 1'b0;
    step();
    chk("t2_drop", rr_valid, 0);

    // Exhaust the tag pool, then recycle tag 7
    req_valid = 1'b1;
    for (int i = 0; i < 27; i++) begin
      req_addr = 64'h4000 + 64'(i) * 64'h80;
      step();
    end
    chk("t3_last_tag", rr_tag, 31);
    chk("t3_out_full", outstanding, 32);
    #1 chk("t3_ack_blk", req_ack, 0);
    rc_valid = 1'b1; rc_last = 1'b1; rc_tag = 5'd7;
    step();
    rc_valid = 1'b0; rc_last = 1'b0;
    chk("t3_out_freed", outstanding, 31);
    req_addr = 64'h9000;
    #1 chk("t3_ack_reuse", req_ack, 1);
    step();
    chk("t3_tag_reuse", rr_tag, 7); chk("t3_addr_reuse", rr_addr, 64'h9000);
    #1 chk("t3_ack_full2", req_ack, 0);
    req_valid = 1'b0;
    step();
    rc_valid = 1'b1; rc_last = 1'b1;
    for (int i = 0; i < 32; i++) begin
      rc_tag = 5'(i);
      step();
    end
    rc_valid = 1'b0; rc_last = 1'b0;
    chk("t3_drain_out", outstanding, 0); chk("t3_drain_idle", idle, 1);
    chk("t3_no_err", error, 0);

    // Abort with a held request
    req_valid = 1'b1; req_addr = 64'hA000; rr_ready = 1'b0;
    step();
    chk("t5_v", rr_valid, 1); chk("t5_g", rr_tag, 0);
    abort = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1 chk("t5_ack_blk", req_ack, 0);
      step();
      chk("t5_hold", rr_valid, 1);
    end
    rr_ready = 1'b1;
    #1 chk("t5_ack_abort", req_ack, 0);
    step();
    chk("t5_drop", rr_valid, 0); chk("t5_out", outstanding, 1); chk("t5_busy", idle, 0);
    req_valid = 1'b0; abort = 1'b0;
    rc_valid = 1'b1; rc_last = 1'b1; rc_tag = 5'd0;
    step();
    rc_valid = 1'b0; rc_last = 1'b0;
    chk("t5_idle", idle, 1); chk("t5_err", error, 0);

    // Credit limit on the 4-unit instance
    req_valid2 = 1'b1;
    #1 chk("t4_ack0", req_ack2, 1);
    for (int i = 0; i < 4; i++) step();
    chk("t4_out", outstanding2, 4);
    #1 chk("t4_blk", req_ack2, 0);
    credit_return2 = 1'b1;
    #1 chk("t4_blk_ret", req_ack2, 0);
    step();
    #1 chk("t4_ack_sim", req_ack2, 1);
    step();
    credit_return2 = 1'b0;
    #1 chk("t4_ack_after_sim", req_ack2, 1);
    step();
    #1 chk("t4_blk2", req_ack2, 0);
    req_valid2 = 1'b0; credit_return2 = 1'b1;
    for (int i = 0; i < 4; i++) step();
    chk("t4_full_noerr", error2, 0);
    step();
    credit_return2 = 1'b0;
    chk("t6_credit_err", error2, 1);
    req_valid2 = 1'b1;
    for (int i = 0; i < 4; i++) step();
    req_valid2 = 1'b0;
    step();
    chk("t6_credit_err_sticky", error2, 1);
    req_valid2 = 1'b1;
    #1 chk("t6_dut2_empty", req_ack2, 0);

    // Spurious completion on a free tag
    rc_valid = 1'b1; rc_last = 1'b1; rc_tag = 5'd3;
    step();
    rc_valid = 1'b0; rc_last = 1'b0;
    chk("t6_tag_err", error, 1); chk("t6_tag_mask", outstanding, 0);
    step();
    chk("t6_tag_sticky", error, 1);

    // Asynchronous reset mid-burst
    req_valid = 1'b1; req_addr = 64'hB000; rr_ready = 1'b0;
    step();
    chk("t6_pre_v", rr_valid, 1);
    #2 reset_n = 1'b0;
    #1;
    chk("t6_rst_v", rr_valid, 0); chk("t6_rst_idle", idle, 1);
    chk("t6_rst_out", outstanding, 0); chk("t6_rst_err", error, 0);
    chk("t6_rst_ack", req_ack, 0); chk("t6_rst_err2", error2, 0);
    step();
    reset_n = 1'b1;
    #1 chk("t6_credit_restored", req_ack2, 1);
    chk("t6_ack_after_rst", req_ack, 1);
    step();
    chk("t6_tag_after_rst", rr_tag, 0); chk("t6_addr_after_rst", rr_addr, 64'hB000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
